alu_operand_sequencer: RTL

ALU_OPERAND_SEQUENCER -- requirements
Module: alu_operand_sequencer

---
 rtl/alu_seq_pkg.sv | 28 ++
 rtl/enter_edge_pulse.sv | 22 ++
 rtl/alu_operand_sequencer.sv | 112 +++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// Shared encodings for the ALU operand sequencer: FSM states and the
// operation codes understood by the downstream ALU.
package alu_seq_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned OP_W    = 3;
  localparam int unsigned CNT_W   = 8;

  typedef enum logic [STATE_W-1:0] {
    ST_LOAD_A  = 3'd0,
    ST_LOAD_B  = 3'd1,
    ST_LOAD_OP = 3'd2,
    ST_EXEC    = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_NOT = 3'b010,
    OP_AND = 3'b011,
    OP_OR  = 3'b100,
    OP_XOR = 3'b101,
    OP_LT  = 3'b110,
    OP_EQ  = 3'b111
  } alu_op_e;

endpackage

// File: rtl/enter_edge_pulse.sv
// Rising-edge detector for the enter button. History is registered; the
// pulse is high for the single cycle in which the level first reads 1.
module enter_edge_pulse (
  input  logic clk_i,
  input  logic rst_i,
  input  logic enter_i,
  output logic pulse_o
);

  logic prev_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= enter_i;
    end
  end

  assign pulse_o = enter_i & ~prev_q;

endmodule

// File: rtl/alu_operand_sequencer.sv
// Steps a user through entering operand A, operand B and an operation,
// then captures the external ALU's result and counts completed executions.
module alu_operand_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             input_clk,
  input  logic             input_rst,
  input  logic [WIDTH-1:0] input_switch,
  input  logic [2:0]       input_mode,
  input  logic             input_enter,
  input  logic             input_clear,
  output logic [WIDTH-1:0] output_a,
  output logic [WIDTH-1:0] output_b,
  output logic [2:0]       output_mode,
  input  logic [WIDTH-1:0] input_alu_result,
  output logic [WIDTH-1:0] output_result,
  output logic             output_result_valid,
  output logic             output_zero,
  output logic [2:0]       output_state,
  output logic [7:0]       output_op_count
);

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [2:0]       mode_q;
  logic [WIDTH-1:0] result_q;
  logic             valid_q;
  logic             zero_q;
  logic [7:0]       cnt_q;
  logic [7:0]       cnt_d;
  logic             press;

  // Edge history is cleared only by reset so a button held through a
  // clear does not produce a press once the clear drops.
  enter_edge_pulse u_enter_edge (
    .clk_i   (input_clk),
    .rst_i   (input_rst),
    .enter_i (input_enter),
    .pulse_o (press)
  );

  assign cnt_d = cnt_q + 8'd1;

  always_ff @(posedge input_clk) begin
    if (input_rst) begin
      state_q  <= ST_LOAD_A;
      a_q      <= '0;
      b_q      <= '0;
      mode_q   <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
      zero_q   <= 1'b0;
      cnt_q    <= '0;
    end else if (input_clear) begin
      state_q  <= ST_LOAD_A;
      a_q      <= '0;
      b_q      <= '0;
      mode_q   <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_LOAD_A: begin
          if (press) begin
            a_q     <= input_switch;
            state_q <= ST_LOAD_B;
          end
        end
        ST_LOAD_B: begin
          if (press) begin
            b_q     <= input_switch;
            state_q <= ST_LOAD_OP;
          end
        end
        ST_LOAD_OP: begin
          if (press) begin
            mode_q  <= input_mode;
            state_q <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          result_q <= input_alu_result;
          zero_q   <= (input_alu_result == '0);
          valid_q  <= 1'b1;
          cnt_q    <= cnt_d;
          state_q  <= ST_DONE;
        end
        ST_DONE: begin
          if (press) begin
            valid_q <= 1'b0;
            state_q <= ST_LOAD_A;
          end
        end
        default: state_q <= ST_LOAD_A;
      endcase
    end
  end

  assign output_a            = a_q;
  assign output_b            = b_q;
  assign output_mode         = mode_q;
  assign output_result       = result_q;
  assign output_result_valid = valid_q;
  assign output_zero         = zero_q;
  assign output_state        = state_q;
  assign output_op_count     = cnt_q;

endmodule
